// File: rtl/crc_stream_pkg.sv
// Shared types and bit-level CRC helpers for the streaming CRC engine.
package crc_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } crc_state_t;

  localparam int CRC_MAX_WIDTH = 32;

  function automatic logic [7:0] reflect8(input logic [7:0] value);
    logic [7:0] r;
    r = {<<{value}};
    return r;
  endfunction

  // Bit-reverse the low 'width' bits; the result sits in the low bits.
  function automatic logic [31:0] reflect_n(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = {<<{value}};
    return r >> (CRC_MAX_WIDTH - width);
  endfunction

  // One byte through the MSB-first shift/XOR register, truncated to 'width' bits.
  function automatic logic [31:0] crc_byte_step(input logic [31:0] crc, input logic [7:0] data,
                                                input logic [31:0] poly, input int width);
    logic [31:0] mask;
    logic [31:0] top;
    logic [31:0] c;
    logic [7:0]  d;
    logic        fb;
    mask = 32'((64'd1 << width) - 64'd1);
    top  = 32'(64'd1 << (width - 1));
    c    = crc & mask;
    d    = data;
    for (int i = 0; i < 8; i++) begin
      fb = ((c & top) != 32'd0) ^ d[7];
      c  = (c << 1) & mask;
      if (fb) c = c ^ (poly & mask);
      d  = d << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_beat_next.sv
// Combinational next-CRC for one beat: kept bytes are folded in ascending order, others skipped.
module crc_beat_next
  import crc_stream_pkg::*;
#(
  parameter int          CRC_WIDTH  = 8,
  parameter logic [31:0] POLY       = 32'h07,
  parameter bit          REFIN      = 1'b0,
  parameter int          DATA_WIDTH = 32
) (
  input  logic [CRC_WIDTH-1:0]    i_crc,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_keep,
  output logic [CRC_WIDTH-1:0]    o_crc
);

  localparam int NB = DATA_WIDTH / 8;

  logic [31:0]           w_c;
  logic [DATA_WIDTH-1:0] w_d;
  logic [NB-1:0]         w_k;
  logic [7:0]            w_b;

  always_comb begin
    w_c = 32'(i_crc);
    w_d = i_data;
    w_k = i_keep;
    w_b = '0;
    for (int n = 0; n < NB; n++) begin
      w_b = REFIN ? reflect8(w_d[7:0]) : w_d[7:0];
      if (w_k[0]) w_c = crc_byte_step(w_c, w_b, POLY, CRC_WIDTH);
      w_d = w_d >> 8;
      w_k = w_k >> 1;
    end
    o_crc = CRC_WIDTH'(w_c);
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming multi-beat CRC engine with valid/ready on both sides and one registered result per frame.
// Define CRC_STREAM_CHECK_EN to add the m_crc_ok residue-match output.
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int          CRC_WIDTH  = 8,
  parameter logic [31:0] POLY       = 32'h07,
  parameter logic [31:0] INIT       = 32'h00,
  parameter bit          REFIN      = 1'b0,
  parameter bit          REFOUT     = 1'b0,
  parameter logic [31:0] XOR_OUT    = 32'h00,
  parameter int          DATA_WIDTH = 32
`ifdef CRC_STREAM_CHECK_EN
  ,
  parameter logic [31:0] CHECK_RESIDUE = 32'h00
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [CRC_WIDTH-1:0]    m_crc,
  output logic                    m_valid,
  input  logic                    m_ready
`ifdef CRC_STREAM_CHECK_EN
  ,
  output logic                    m_crc_ok
`endif
);

  localparam logic [CRC_WIDTH-1:0] INIT_T = INIT[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] XOR_T  = XOR_OUT[CRC_WIDTH-1:0];

  crc_state_t           r_state;
  crc_state_t           w_state_next;
  logic [CRC_WIDTH-1:0] r_acc;
  logic [CRC_WIDTH-1:0] r_crc;
  logic                 r_valid;
  logic [CRC_WIDTH-1:0] w_crc_start;
  logic [CRC_WIDTH-1:0] w_crc_beat;
  logic [CRC_WIDTH-1:0] w_result;
  logic                 w_accept;
  logic                 w_frame_done;

  // Ready depends only on the output register and m_ready, never on s_valid.
  assign s_ready      = !r_valid | m_ready;
  assign w_accept     = s_valid & s_ready;
  assign w_frame_done = w_accept & s_last;
  assign w_crc_start  = (r_state == IDLE) ? INIT_T : r_acc;

  crc_beat_next #(
    .CRC_WIDTH  (CRC_WIDTH),
    .POLY       (POLY),
    .REFIN      (REFIN),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_beat_next (
    .i_crc  (w_crc_start),
    .i_data (s_data),
    .i_keep (s_keep),
    .o_crc  (w_crc_beat)
  );

  always_comb begin
    w_result = w_crc_beat;
    if (REFOUT) w_result = CRC_WIDTH'(reflect_n(32'(w_crc_beat), CRC_WIDTH));
    w_result = w_result ^ XOR_T;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) w_state_next = s_last ? IDLE : ACCUM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= INIT_T;
      r_crc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_acc <= s_last ? INIT_T : w_crc_beat;
      // A new result may replace one being consumed in the same cycle.
      if (w_frame_done) begin
        r_crc   <= w_result;
        r_valid <= 1'b1;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef CRC_STREAM_CHECK_EN
  logic r_crc_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc_ok <= 1'b0;
    end else if (w_frame_done) begin
      r_crc_ok <= (w_result == CRC_WIDTH'(CHECK_RESIDUE));
    end
  end

  assign m_crc_ok = r_crc_ok;
`endif

  assign m_crc   = r_crc;
  assign m_valid = r_valid;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: CRC-8, CRC-16/CCITT-FALSE and CRC-32 instances on one clock.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // CRC-8 defaults, one byte per beat
  logic [7:0]  s_data8 = '0;
  logic [0:0]  s_keep8 = '0;
  logic        s_last8 = 1'b0, s_valid8 = 1'b0, s_ready8;
  logic [7:0]  m_crc8;
  logic        m_valid8, m_ready8 = 1'b0;
  // CRC-16/CCITT-FALSE, 4 bytes per beat
  logic [31:0] s_data16 = '0;
  logic [3:0]  s_keep16 = '0;
  logic        s_last16 = 1'b0, s_valid16 = 1'b0, s_ready16;
  logic [15:0] m_crc16;
  logic        m_valid16, m_ready16 = 1'b0;
  // CRC-32 (reflected), 4 bytes per beat
  logic [31:0] s_data32 = '0;
  logic [3:0]  s_keep32 = '0;
  logic        s_last32 = 1'b0, s_valid32 = 1'b0, s_ready32;
  logic [31:0] m_crc32;
  logic        m_valid32, m_ready32 = 1'b0;
`ifdef CRC_STREAM_CHECK_EN
  logic        m_crc_ok8, m_crc_ok16, m_crc_ok32;
`endif

  crc_stream_engine #(
    .CRC_WIDTH(8), .POLY(32'h07), .INIT(32'h00), .REFIN(1'b0), .REFOUT(1'b0),
    .XOR_OUT(32'h00), .DATA_WIDTH(8)
  ) u_crc8 (
    .clk(clk), .reset(reset), .s_data(s_data8), .s_keep(s_keep8), .s_last(s_last8),
    .s_valid(s_valid8), .s_ready(s_ready8), .m_crc(m_crc8), .m_valid(m_valid8),
    .m_ready(m_ready8)
`ifdef CRC_STREAM_CHECK_EN
    , .m_crc_ok(m_crc_ok8)
`endif
  );

  crc_stream_engine #(
    .CRC_WIDTH(16), .POLY(32'h1021), .INIT(32'hFFFF), .REFIN(1'b0), .REFOUT(1'b0),
    .XOR_OUT(32'h0000), .DATA_WIDTH(32)
  ) u_crc16 (
    .clk(clk), .reset(reset), .s_data(s_data16), .s_keep(s_keep16), .s_last(s_last16),
    .s_valid(s_valid16), .s_ready(s_ready16), .m_crc(m_crc16), .m_valid(m_valid16),
    .m_ready(m_ready16)
`ifdef CRC_STREAM_CHECK_EN
    , .m_crc_ok(m_crc_ok16)
`endif
  );

  crc_stream_engine #(
    .CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1),
    .XOR_OUT(32'hFFFFFFFF), .DATA_WIDTH(32)
  ) u_crc32 (
    .clk(clk), .reset(reset), .s_data(s_data32), .s_keep(s_keep32), .s_last(s_last32),
    .s_valid(s_valid32), .s_ready(s_ready32), .m_crc(m_crc32), .m_valid(m_valid32),
    .m_ready(m_ready32)
`ifdef CRC_STREAM_CHECK_EN
    , .m_crc_ok(m_crc_ok32)
`endif
  );

  // Each beat task returns 1 time unit after the accepting edge.
  task automatic beat8(input logic [7:0] d, input logic last);
    @(negedge clk);
    s_data8 = d; s_keep8 = 1'b1; s_last8 = last; s_valid8 = 1'b1;
    @(posedge clk); #1;
    s_valid8 = 1'b0;
  endtask

  task automatic beat16(input logic [31:0] d, input logic [3:0] k, input logic last);
    @(negedge clk);
    s_data16 = d; s_keep16 = k; s_last16 = last; s_valid16 = 1'b1;
    @(posedge clk); #1;
    s_valid16 = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic last);
    @(negedge clk);
    s_data32 = d; s_keep32 = k; s_last32 = last; s_valid32 = 1'b1;
    @(posedge clk); #1;
    s_valid32 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m_valid8 !== 1'b0) begin n_bad++; $display("FAIL reset_valid8: got %b expected 0", m_valid8); end
    n_cmp++; if (m_crc8 !== 8'h00) begin n_bad++; $display("FAIL reset_crc8: got %h expected 00", m_crc8); end
    n_cmp++; if (m_valid16 !== 1'b0) begin n_bad++; $display("FAIL reset_valid16: got %b expected 0", m_valid16); end
    n_cmp++; if (m_crc16 !== 16'h0000) begin n_bad++; $display("FAIL reset_crc16: got %h expected 0000", m_crc16); end
    n_cmp++; if (m_valid32 !== 1'b0) begin n_bad++; $display("FAIL reset_valid32: got %b expected 0", m_valid32); end
    n_cmp++; if (m_crc32 !== 32'h0) begin n_bad++; $display("FAIL reset_crc32: got %h expected 00000000", m_crc32); end
`ifdef CRC_STREAM_CHECK_EN
    n_cmp++; if (m_crc_ok8 !== 1'b0) begin n_bad++; $display("FAIL reset_ok8: got %b expected 0", m_crc_ok8); end
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (s_ready8 !== 1'b1) begin n_bad++; $display("FAIL reset_sready8: got %b expected 1", s_ready8); end
    n_cmp++; if (s_ready32 !== 1'b1) begin n_bad++; $display("FAIL reset_sready32: got %b expected 1", s_ready32); end
    $display("reset released: s_ready8=%b s_ready16=%b s_ready32=%b", s_ready8, s_ready16, s_ready32);
  endtask

  task automatic test_crc8_string();
    m_ready8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        n_cmp++; if (m_valid8 !== 1'b0) begin n_bad++; $display("FAIL crc8_early_valid: got %b expected 0", m_valid8); end
      end
      beat8(8'(8'h31 + i), i == 8);
    end
    $display("crc8 '123456789': m_valid=%b m_crc=%h", m_valid8, m_crc8);
    n_cmp++; if (m_valid8 !== 1'b1) begin n_bad++; $display("FAIL crc8_valid: got %b expected 1", m_valid8); end
    n_cmp++; if (m_crc8 !== 8'hF4) begin n_bad++; $display("FAIL crc8_string: got %h expected f4", m_crc8); end
    @(posedge clk); #1;
    n_cmp++; if (m_valid8 !== 1'b0) begin n_bad++; $display("FAIL crc8_consumed: got %b expected 0", m_valid8); end
  endtask

  task automatic test_crc16_beats();
    m_ready16 = 1'b1;
    beat16(32'h34333231, 4'hF, 1'b0);
    beat16(32'h38373635, 4'hF, 1'b0);
    beat16(32'h00000039, 4'h1, 1'b1);
    $display("crc16 '123456789' 3 beats: m_crc=%h", m_crc16);
    n_cmp++; if (m_valid16 !== 1'b1) begin n_bad++; $display("FAIL crc16_valid: got %b expected 1", m_valid16); end
    n_cmp++; if (m_crc16 !== 16'h29B1) begin n_bad++; $display("FAIL crc16_string: got %h expected 29b1", m_crc16); end
  endtask

  task automatic test_keep_gaps();
    beat16(32'hAAAAAAAA, 4'b0000, 1'b0);
    beat16(32'h33AA3231, 4'b1011, 1'b0);
    beat16(32'h37363534, 4'b1111, 1'b0);
    beat16(32'h00390038, 4'b0101, 1'b0);
    beat16(32'h55555555, 4'b0000, 1'b1);
    $display("crc16 gapped keep frame: m_crc=%h", m_crc16);
    n_cmp++; if (m_crc16 !== 16'h29B1) begin n_bad++; $display("FAIL crc16_gaps: got %h expected 29b1", m_crc16); end
    beat16(32'h12345678, 4'b0000, 1'b1);
    $display("crc16 empty frame: m_crc=%h", m_crc16);
    n_cmp++; if (m_valid16 !== 1'b1) begin n_bad++; $display("FAIL crc16_empty_valid: got %b expected 1", m_valid16); end
    n_cmp++; if (m_crc16 !== 16'hFFFF) begin n_bad++; $display("FAIL crc16_empty: got %h expected ffff", m_crc16); end
  endtask

  task automatic test_crc32_backpressure();
    m_ready32 = 1'b0;
    beat32(32'h34333231, 4'hF, 1'b0);
    beat32(32'h38373635, 4'hF, 1'b0);
    beat32(32'h00000039, 4'h1, 1'b1);
    $display("crc32 '123456789': m_crc=%h s_ready=%b", m_crc32, s_ready32);
    n_cmp++; if (m_crc32 !== 32'hCBF43926) begin n_bad++; $display("FAIL crc32_string: got %h expected cbf43926", m_crc32); end
    n_cmp++; if (s_ready32 !== 1'b0) begin n_bad++; $display("FAIL crc32_stall_ready: got %b expected 0", s_ready32); end
    // A stalled last beat must neither be taken nor disturb the held result.
    @(negedge clk);
    s_data32 = 32'hDEADBEEF; s_keep32 = 4'hF; s_last32 = 1'b1; s_valid32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m_valid32 !== 1'b1) begin n_bad++; $display("FAIL crc32_hold_valid: got %b expected 1", m_valid32); end
    n_cmp++; if (m_crc32 !== 32'hCBF43926) begin n_bad++; $display("FAIL crc32_hold: got %h expected cbf43926", m_crc32); end
    @(negedge clk);
    s_valid32 = 1'b0;
    m_ready32 = 1'b1;
    #1;
    n_cmp++; if (s_ready32 !== 1'b1) begin n_bad++; $display("FAIL crc32_release_ready: got %b expected 1", s_ready32); end
    @(posedge clk); #1;
    n_cmp++; if (m_valid32 !== 1'b0) begin n_bad++; $display("FAIL crc32_handshake: got %b expected 0", m_valid32); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] din [5];
    logic [7:0] dexp [5];
    din  = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h01};
    dexp = '{8'h00, 8'h07, 8'h89, 8'hF3, 8'h07};
    m_ready8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat8(din[i], 1'b1);
      $display("crc8 single-beat frame %0d: data=%h m_crc=%h m_valid=%b", i, din[i], m_crc8, m_valid8);
      n_cmp++; if (m_valid8 !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, m_valid8); end
      n_cmp++; if (m_crc8 !== dexp[i]) begin n_bad++; $display("FAIL b2b_crc[%0d]: got %h expected %h", i, m_crc8, dexp[i]); end
    end
    @(posedge clk); #1;
    n_cmp++; if (m_valid8 !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b expected 0", m_valid8); end
  endtask

  task automatic test_reset_mid_frame();
    m_ready32 = 1'b0;
    beat32(32'h0, 4'h0, 1'b1);
    n_cmp++; if (m_crc32 !== 32'h00000000) begin n_bad++; $display("FAIL crc32_empty: got %h expected 00000000", m_crc32); end
    n_cmp++; if (m_valid32 !== 1'b1) begin n_bad++; $display("FAIL crc32_pending: got %b expected 1", m_valid32); end
    m_ready16 = 1'b1;
    beat16(32'h34333231, 4'hF, 1'b0);
    beat16(32'h38373635, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (m_valid16 !== 1'b0) begin n_bad++; $display("FAIL midrst_valid16: got %b expected 0", m_valid16); end
    n_cmp++; if (m_valid32 !== 1'b0) begin n_bad++; $display("FAIL midrst_drop32: got %b expected 0", m_valid32); end
    n_cmp++; if (m_crc32 !== 32'h0) begin n_bad++; $display("FAIL midrst_crc32: got %h expected 00000000", m_crc32); end
    @(negedge clk);
    reset = 1'b0;
    m_ready32 = 1'b1;
    beat16(32'h34333231, 4'hF, 1'b0);
    beat16(32'h38373635, 4'hF, 1'b0);
    beat16(32'h00000039, 4'h1, 1'b1);
    $display("crc16 resent after reset: m_crc=%h", m_crc16);
    n_cmp++; if (m_valid16 !== 1'b1) begin n_bad++; $display("FAIL midrst_resend_valid: got %b expected 1", m_valid16); end
    n_cmp++; if (m_crc16 !== 16'h29B1) begin n_bad++; $display("FAIL midrst_resend: got %h expected 29b1", m_crc16); end
  endtask

`ifdef CRC_STREAM_CHECK_EN
  task automatic test_residue();
    m_ready8 = 1'b1;
    for (int i = 0; i < 9; i++) beat8(8'(8'h31 + i), 1'b0);
    beat8(8'hF4, 1'b1);
    $display("crc8 residue with f4: m_crc=%h m_crc_ok=%b", m_crc8, m_crc_ok8);
    n_cmp++; if (m_crc8 !== 8'h00) begin n_bad++; $display("FAIL residue_crc: got %h expected 00", m_crc8); end
    n_cmp++; if (m_crc_ok8 !== 1'b1) begin n_bad++; $display("FAIL residue_ok: got %b expected 1", m_crc_ok8); end
    for (int i = 0; i < 9; i++) beat8(8'(8'h31 + i), 1'b0);
    beat8(8'hF5, 1'b1);
    $display("crc8 residue with f5: m_crc=%h m_crc_ok=%b", m_crc8, m_crc_ok8);
    n_cmp++; if (m_crc8 !== 8'h07) begin n_bad++; $display("FAIL residue_bad_crc: got %h expected 07", m_crc8); end
    n_cmp++; if (m_crc_ok8 !== 1'b0) begin n_bad++; $display("FAIL residue_bad_ok: got %b expected 0", m_crc_ok8); end
  endtask
`endif

  initial begin
    test_reset();
    test_crc8_string();
    test_crc16_beats();
    test_keep_gaps();
    test_crc32_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef CRC_STREAM_CHECK_EN
    test_residue();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
